// File: rtl/gb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gb_pkg: shared types and constants for the memory bus controller.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gb_pkg;

   typedef enum logic [1:0] {
      BUS_IDLE  = 2'b00,
      BUS_READ  = 2'b01,
      BUS_WRITE = 2'b10
   } bus_state_e;

   typedef enum logic [2:0] {
      REG_B      = 3'b000,
      REG_C      = 3'b001,
      REG_D      = 3'b010,
      REG_E      = 3'b011,
      REG_H      = 3'b100,
      REG_L      = 3'b101,
      REG_HL_IND = 3'b110,
      REG_A      = 3'b111
   } reg_sel_e;

   typedef enum logic [1:0] {
      DBUS_SBUS  = 2'b00,
      DBUS_ALU   = 2'b01,
      DBUS_MEM   = 2'b10,
      DBUS_DEBUG = 2'b11
   } dbus_sel_e;

   localparam logic [15:0] RESET_PC = 16'h0000;

   function automatic logic bus_active(input bus_state_e s);
      return (s == BUS_READ) || (s == BUS_WRITE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_ctrl_if: decoder request side and external memory bus signals.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bus_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [1:0]        t_cycle;
   logic              rd;
   logic              wr;
   logic              reg_drive_addr;
   logic [ADDR_W-1:0] reg_addr_in;
   logic [DATA_W-1:0] wr_data;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_val;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_n;
   logic              mem_wr_n;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_data_oe;
   logic [DATA_W-1:0] data_bus_out;
   logic [ADDR_W-1:0] pc;
   logic              stall;
   logic              bus_err;

   modport master (
      input  t_cycle, rd, wr, reg_drive_addr, reg_addr_in, wr_data,
             pc_load, pc_load_val, mem_data_in, mem_ready,
      output mem_addr, mem_rd_n, mem_wr_n, mem_data_out, mem_data_oe,
             data_bus_out, pc, stall, bus_err
   );

   modport slave (
      output t_cycle, rd, wr, reg_drive_addr, reg_addr_in, wr_data,
             pc_load, pc_load_val, mem_data_in, mem_ready,
      input  mem_addr, mem_rd_n, mem_wr_n, mem_data_out, mem_data_oe,
             data_bus_out, pc, stall, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | program_counter: PC register, priority load > increment > hold.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module program_counter #(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              load_i,
   input  wire logic [ADDR_W-1:0] load_val_i,
   input  wire logic              inc_i,
   output logic      [ADDR_W-1:0] pc_o
);
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;
endmodule
`default_nettype wire

// File: rtl/bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_ctrl: memory bus controller feeding the decoder, with waits.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bus_ctrl #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter int                WAIT_MAX = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(gb_pkg::RESET_PC)
) (
   input wire logic   clk,
   input wire logic   rst,
   bus_ctrl_if.master bus
);
   import gb_pkg::*;

   // Abort fires on the edge that ends the WAIT_MAX-th consecutive wait cycle
   localparam logic [3:0] c_wait_last = 4'(WAIT_MAX - 1);

   bus_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              addr_is_pc_q, addr_is_pc_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] dbuf_q, dbuf_d;
   logic [3:0]        wait_q, wait_d;
   logic              err_q, err_d;
   logic              w_pc_inc;
   logic [ADDR_W-1:0] w_pc;

   program_counter #(
      .ADDR_W    (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .load_i     (bus.pc_load),
      .load_val_i (bus.pc_load_val),
      .inc_i      (w_pc_inc),
      .pc_o       (w_pc)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      addr_is_pc_d = addr_is_pc_q;
      wdata_d      = wdata_q;
      dbuf_d       = dbuf_q;
      wait_d       = wait_q;
      err_d        = err_q;
      w_pc_inc     = 1'b0;

      case (state_q)
         BUS_IDLE: begin
            if (bus.t_cycle == 2'b01) begin
               addr_d       = bus.reg_drive_addr ? bus.reg_addr_in : w_pc;
               addr_is_pc_d = ~bus.reg_drive_addr;
            end
            if (bus.rd) begin
               state_d = BUS_READ;
               if (bus.wr) begin
                  err_d = 1'b1;
               end
            end else if (bus.wr) begin
               state_d = BUS_WRITE;
               wdata_d = bus.wr_data;
            end
         end
         BUS_READ: begin
            if (bus.mem_ready) begin
               dbuf_d   = bus.mem_data_in;
               w_pc_inc = addr_is_pc_q;
               wait_d   = '0;
               state_d  = BUS_IDLE;
            end else if (wait_q == c_wait_last) begin
               dbuf_d  = {DATA_W{1'b1}};
               err_d   = 1'b1;
               wait_d  = '0;
               state_d = BUS_IDLE;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         BUS_WRITE: begin
            if (bus.mem_ready) begin
               wait_d  = '0;
               state_d = BUS_IDLE;
            end else if (wait_q == c_wait_last) begin
               err_d   = 1'b1;
               wait_d  = '0;
               state_d = BUS_IDLE;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         default: begin
            state_d = BUS_IDLE;
            wait_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= BUS_IDLE;
         addr_q       <= '0;
         addr_is_pc_q <= 1'b1;
         wdata_q      <= '0;
         dbuf_q       <= '0;
         wait_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         addr_is_pc_q <= addr_is_pc_d;
         wdata_q      <= wdata_d;
         dbuf_q       <= dbuf_d;
         wait_q       <= wait_d;
         err_q        <= err_d;
      end
   end

   // Strobes decode straight from the state register so reset releases them at once
   assign bus.mem_addr     = addr_q;
   assign bus.mem_rd_n     = (state_q != BUS_READ);
   assign bus.mem_wr_n     = (state_q != BUS_WRITE);
   assign bus.mem_data_out = wdata_q;
   assign bus.mem_data_oe  = (state_q == BUS_WRITE);
   assign bus.data_bus_out = dbuf_q;
   assign bus.pc           = w_pc;
   assign bus.stall        = bus_active(state_q) && !bus.mem_ready;
   assign bus.bus_err      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_ctrl: scoreboard bench for bus_ctrl fetch/read/write/abort.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bus_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct packed {
      logic [7:0]  data;
      logic [15:0] pc;
   } exp_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          rd_cyc;
      int          wr_cyc;
      int          oe_cyc;
      int          stall_cyc;
      logic        done;
   } acc_t;

   exp_t        exp_q[$];
   logic [15:0] model_pc;

   always #5 clk = ~clk;

   bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   bus_ctrl #(
      .ADDR_W   (16),
      .DATA_W   (8),
      .WAIT_MAX (15),
      .RESET_PC (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // One T1..T4 bus cycle; waits < 0 holds mem_ready low indefinitely
   task automatic bus_access(input logic do_rd, input logic do_wr, input logic use_reg,
                             input logic [15:0] raddr, input logic [7:0] wdata,
                             input logic [7:0] rdata, input int waits,
                             input logic load_at_done, input logic [15:0] load_val,
                             output acc_t res);
      res = '0;
      bus.t_cycle = 2'b00; bus.rd = 1'b0; bus.wr = 1'b0;
      bus.pc_load = 1'b0; bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.t_cycle = 2'b01; bus.reg_drive_addr = use_reg; bus.reg_addr_in = raddr;
      @(posedge clk); #1;
      res.addr = bus.mem_addr;
      bus.t_cycle = 2'b10; bus.rd = do_rd; bus.wr = do_wr; bus.wr_data = wdata;
      @(posedge clk); #1;
      bus.t_cycle = 2'b11; bus.rd = 1'b0; bus.wr = 1'b0; bus.mem_data_in = rdata;
      for (int c = 0; c < 40; c++) begin
         bus.mem_ready   = (waits >= 0) && (c >= waits);
         bus.pc_load     = load_at_done && bus.mem_ready;
         bus.pc_load_val = load_val;
         #1;
         if (bus.mem_rd_n && bus.mem_wr_n) begin
            res.done = 1'b1;
            break;
         end
         if (!bus.mem_rd_n)   res.rd_cyc    = res.rd_cyc + 1;
         if (!bus.mem_wr_n)   res.wr_cyc    = res.wr_cyc + 1;
         if (bus.stall)       res.stall_cyc = res.stall_cyc + 1;
         if (bus.mem_data_oe) begin
            res.oe_cyc = res.oe_cyc + 1;
            res.wdata  = bus.mem_data_out;
         end
         @(posedge clk); #1;
      end
      bus.pc_load = 1'b0; bus.mem_ready = 1'b1; bus.t_cycle = 2'b00;
      #1;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({bus.mem_rd_n, bus.mem_wr_n, bus.mem_data_oe, bus.stall} !== 4'b1100) begin
         n_errors++;
         $display("FAIL reset_strobes: got %b required 1100",
                  {bus.mem_rd_n, bus.mem_wr_n, bus.mem_data_oe, bus.stall});
      end
      n_checks++;
      if ({bus.mem_addr, bus.mem_data_out, bus.data_bus_out} !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_data: got addr=%h dout=%h dbus=%h required zeros",
                  bus.mem_addr, bus.mem_data_out, bus.data_bus_out);
      end
      n_checks++;
      if (bus.pc !== 16'h0000 || bus.bus_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_pc_err: got pc=%h err=%b required 0000/0", bus.pc, bus.bus_err);
      end
      model_pc = 16'h0000;
   endtask

   task automatic test_fetch();
      acc_t r;
      exp_t e;
      exp_q.push_back('{data: 8'h3C, pc: model_pc + 16'd1});
      bus_access(1'b1, 1'b0, 1'b0, 16'hDEAD, 8'h00, 8'h3C, 0, 1'b0, 16'h0, r);
      model_pc = model_pc + 16'd1;
      e = exp_q.pop_front();
      n_checks++;
      if (r.addr !== 16'h0000) begin
         n_errors++; $display("FAIL fetch_addr: got %h required 0000", r.addr);
      end
      n_checks++;
      if (r.rd_cyc !== 1 || r.stall_cyc !== 0 || r.done !== 1'b1) begin
         n_errors++;
         $display("FAIL fetch_strobe: got rd=%0d stall=%0d done=%b required 1/0/1",
                  r.rd_cyc, r.stall_cyc, r.done);
      end
      n_checks++;
      if (bus.data_bus_out !== e.data || bus.pc !== e.pc) begin
         n_errors++;
         $display("FAIL fetch_data: got data=%h pc=%h required %h/%h",
                  bus.data_bus_out, bus.pc, e.data, e.pc);
      end
   endtask

   task automatic test_hl_read_waits();
      acc_t r;
      exp_t e;
      exp_q.push_back('{data: 8'h5A, pc: model_pc});
      bus_access(1'b1, 1'b0, 1'b1, 16'hC000, 8'h00, 8'h5A, 3, 1'b0, 16'h0, r);
      e = exp_q.pop_front();
      n_checks++;
      if (r.addr !== 16'hC000) begin
         n_errors++; $display("FAIL hl_addr: got %h required C000", r.addr);
      end
      n_checks++;
      if (r.rd_cyc !== 4 || r.stall_cyc !== 3) begin
         n_errors++;
         $display("FAIL hl_waits: got rd=%0d stall=%0d required 4/3", r.rd_cyc, r.stall_cyc);
      end
      n_checks++;
      if (bus.data_bus_out !== e.data || bus.pc !== e.pc || bus.bus_err !== 1'b0) begin
         n_errors++;
         $display("FAIL hl_data: got data=%h pc=%h err=%b required %h/%h/0",
                  bus.data_bus_out, bus.pc, bus.bus_err, e.data, e.pc);
      end
   endtask

   task automatic test_write();
      acc_t       r;
      logic [7:0] dbus_before;
      for (int i = 0; i < 2; i++) begin
         dbus_before = bus.data_bus_out;
         bus_access(1'b0, 1'b1, 1'b1, 16'hFF80, 8'hA5 ^ 8'(i), 8'h11, 2 * i, 1'b0, 16'h0, r);
         n_checks++;
         if (r.addr !== 16'hFF80 || r.wdata !== (8'hA5 ^ 8'(i))) begin
            n_errors++;
            $display("FAIL write_addr_data[%0d]: got %h/%h required FF80/%h",
                     i, r.addr, r.wdata, 8'hA5 ^ 8'(i));
         end
         n_checks++;
         if (r.wr_cyc !== 1 + 2 * i || r.oe_cyc !== 1 + 2 * i || r.rd_cyc !== 0
             || r.stall_cyc !== 2 * i) begin
            n_errors++;
            $display("FAIL write_strobe[%0d]: got wr=%0d oe=%0d rd=%0d stall=%0d required %0d/%0d/0/%0d",
                     i, r.wr_cyc, r.oe_cyc, r.rd_cyc, r.stall_cyc, 1 + 2 * i, 1 + 2 * i, 2 * i);
         end
         n_checks++;
         if (bus.pc !== model_pc || bus.data_bus_out !== dbus_before) begin
            n_errors++;
            $display("FAIL write_side_effect[%0d]: got pc=%h dbus=%h required %h/%h",
                     i, bus.pc, bus.data_bus_out, model_pc, dbus_before);
         end
      end
   endtask

   task automatic test_back_to_back();
      acc_t       r;
      exp_t       e;
      logic [7:0] d;
      int         w;
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(1, 254));
         w = i % 3;
         exp_q.push_back('{data: d, pc: model_pc + 16'd1});
         bus_access(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, d, w, 1'b0, 16'h0, r);
         n_checks++;
         if (r.addr !== model_pc || r.stall_cyc !== w) begin
            n_errors++;
            $display("FAIL b2b_addr[%0d]: got addr=%h stall=%0d required %h/%0d",
                     i, r.addr, r.stall_cyc, model_pc, w);
         end
         model_pc = model_pc + 16'd1;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.data_bus_out !== e.data || bus.pc !== e.pc) begin
            n_errors++;
            $display("FAIL b2b_data[%0d]: got data=%h pc=%h required %h/%h",
                     i, bus.data_bus_out, bus.pc, e.data, e.pc);
         end
      end
   endtask

   task automatic test_rd_wr_conflict();
      acc_t r;
      bus_access(1'b1, 1'b1, 1'b1, 16'h1234, 8'h42, 8'h6E, 0, 1'b0, 16'h0, r);
      n_checks++;
      if (r.rd_cyc !== 1 || r.wr_cyc !== 0 || r.oe_cyc !== 0) begin
         n_errors++;
         $display("FAIL conflict_strobe: got rd=%0d wr=%0d oe=%0d required 1/0/0",
                  r.rd_cyc, r.wr_cyc, r.oe_cyc);
      end
      n_checks++;
      if (bus.bus_err !== 1'b1 || bus.data_bus_out !== 8'h6E || bus.pc !== model_pc) begin
         n_errors++;
         $display("FAIL conflict_result: got err=%b data=%h pc=%h required 1/6E/%h",
                  bus.bus_err, bus.data_bus_out, bus.pc, model_pc);
      end
   endtask

   task automatic test_reset_mid_read();
      bus.t_cycle = 2'b00; bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.t_cycle = 2'b01; bus.reg_drive_addr = 1'b0;
      @(posedge clk); #1;
      bus.t_cycle = 2'b10; bus.rd = 1'b1;
      @(posedge clk); #1;
      bus.t_cycle = 2'b11; bus.rd = 1'b0; bus.mem_ready = 1'b0; bus.mem_data_in = 8'h99;
      @(posedge clk); #1;
      n_checks++;
      if (bus.stall !== 1'b1 || bus.mem_rd_n !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_wait: got stall=%b rd_n=%b required 1/0", bus.stall, bus.mem_rd_n);
      end
      // Ready rises together with reset so an ignored reset would complete the read
      rst = 1'b1; bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.t_cycle = 2'b00;
      #1;
      model_pc = 16'h0000;
      exp_q.delete();
      n_checks++;
      if (bus.mem_rd_n !== 1'b1 || bus.stall !== 1'b0 || bus.pc !== 16'h0000) begin
         n_errors++;
         $display("FAIL midrst_state: got rd_n=%b stall=%b pc=%h required 1/0/0000",
                  bus.mem_rd_n, bus.stall, bus.pc);
      end
      n_checks++;
      if (bus.data_bus_out !== 8'h00 || bus.bus_err !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_data: got data=%h err=%b required 00/0",
                  bus.data_bus_out, bus.bus_err);
      end
   endtask

   task automatic test_timeout();
      acc_t r;
      exp_t e;
      exp_q.push_back('{data: 8'hFF, pc: model_pc});
      bus_access(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h12, -1, 1'b0, 16'h0, r);
      e = exp_q.pop_front();
      n_checks++;
      if (r.done !== 1'b1 || r.stall_cyc !== 15 || r.rd_cyc !== 15) begin
         n_errors++;
         $display("FAIL timeout_len: got done=%b stall=%0d rd=%0d required 1/15/15",
                  r.done, r.stall_cyc, r.rd_cyc);
      end
      n_checks++;
      if (bus.bus_err !== 1'b1 || bus.data_bus_out !== e.data || bus.pc !== e.pc) begin
         n_errors++;
         $display("FAIL timeout_result: got err=%b data=%h pc=%h required 1/%h/%h",
                  bus.bus_err, bus.data_bus_out, bus.pc, e.data, e.pc);
      end
   endtask

   task automatic test_wrap_priority();
      acc_t r;
      exp_t e;
      bus.pc_load = 1'b1; bus.pc_load_val = 16'hFFFF;
      @(posedge clk); #1;
      bus.pc_load = 1'b0;
      #1;
      model_pc = 16'hFFFF;
      n_checks++;
      if (bus.pc !== 16'hFFFF) begin
         n_errors++; $display("FAIL idle_load: got pc=%h required FFFF", bus.pc);
      end
      exp_q.push_back('{data: 8'h77, pc: 16'h0000});
      bus_access(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h77, 0, 1'b0, 16'h0, r);
      e = exp_q.pop_front();
      n_checks++;
      if (r.addr !== 16'hFFFF || bus.pc !== e.pc || bus.data_bus_out !== e.data) begin
         n_errors++;
         $display("FAIL wrap: got addr=%h pc=%h data=%h required FFFF/%h/%h",
                  r.addr, bus.pc, bus.data_bus_out, e.pc, e.data);
      end
      exp_q.push_back('{data: 8'h88, pc: 16'h0150});
      bus_access(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h88, 1, 1'b1, 16'h0150, r);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc !== e.pc || bus.data_bus_out !== e.data) begin
         n_errors++;
         $display("FAIL load_priority: got pc=%h data=%h required %h/%h",
                  bus.pc, bus.data_bus_out, e.pc, e.data);
      end
      bus_access(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h01, 0, 1'b0, 16'h0, r);
      n_checks++;
      if (r.addr !== 16'h0150 || bus.pc !== 16'h0151 || bus.bus_err !== 1'b1) begin
         n_errors++;
         $display("FAIL post_load_fetch: got addr=%h pc=%h err=%b required 0150/0151/1",
                  r.addr, bus.pc, bus.bus_err);
      end
   endtask

   initial begin
      bus.t_cycle = 2'b00; bus.rd = 1'b0; bus.wr = 1'b0;
      bus.reg_drive_addr = 1'b0; bus.reg_addr_in = 16'h0; bus.wr_data = 8'h0;
      bus.pc_load = 1'b0; bus.pc_load_val = 16'h0;
      bus.mem_data_in = 8'h0; bus.mem_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      test_reset();
      test_fetch();
      test_hl_read_waits();
      test_write();
      test_back_to_back();
      test_rd_wr_conflict();
      test_reset_mid_read();
      test_timeout();
      test_wrap_priority();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
               n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/bus_ctrl.md
# bus_ctrl

Memory bus controller directly upstream of the instruction decoder. It owns the program counter, drives the external address and strobes, and inserts wait states. It latches read data into a memory data buffer that feeds the decoder's `data_bus_in`, so the opcode is stable when `m1t1` rises. It also executes single-byte writes.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 8, data width
- `WAIT_MAX`, 15, maximum consecutive `mem_ready`-low cycles before abort
- `RESET_PC`, 16'h0000, PC value after reset

Ports:
- `clk` in 1: single clock; one clk = one T-cycle
- `rst` in 1: synchronous, active-high reset
- `t_cycle` in 2: current T-cycle from decoder (00=T1 … 11=T4)
- `rd` in 1: read request from decoder
- `wr` in 1: write request
- `reg_drive_addr` in 1: 1 = address from `reg_addr_in`, 0 = PC
- `reg_addr_in` in ADDR_W: 16-bit register-pair address from register file
- `wr_data` in DATA_W: byte to write
- `pc_load` in 1: load PC (jumps)
- `pc_load_val` in ADDR_W: PC load value
- `mem_data_in` in DATA_W: external read data
- `mem_ready` in 1: external ready; low = wait state
- `mem_addr` out ADDR_W: registered bus address
- `mem_rd_n` out 1: read strobe, active-low
- `mem_wr_n` out 1: write strobe, active-low
- `mem_data_out` out DATA_W: write data
- `mem_data_oe` out 1: write-data output enable
- `data_bus_out` out DATA_W: memory data buffer, routed to decoder `data_bus_in`
- `pc` out ADDR_W: current program counter
- `stall` out 1: access pending with `mem_ready` low; decoder freezes its cycle counter
- `bus_err` out 1: sticky error flag

## Operation
**FSM states:** IDLE, READ, WRITE.

**Address latch**
- In IDLE, on an edge where `t_cycle`==01, `mem_addr` ← (`reg_drive_addr` ? `reg_addr_in` : `pc`).
- `addr_is_pc` records which source was used.

**IDLE transitions**
- `rd`=1 → READ.
- `wr`=1 and `rd`=0 → WRITE; latch `wr_data` into `mem_data_out`.
- `rd` and `wr` both 1 → READ; `bus_err` ← 1.

**READ**
- `mem_rd_n`=0.
- On an edge with `mem_ready`=1: `data_bus_out` ← `mem_data_in`; if `addr_is_pc`, `pc` ← `pc`+1 mod 2^ADDR_W (FFFF→0000); → IDLE.

**WRITE**
- `mem_wr_n`=0, `mem_data_oe`=1.
- On an edge with `mem_ready`=1 → IDLE; the PC is unchanged.

**Wait handling**
- `wait_cnt` (4 bits) counts consecutive `mem_ready`=0 cycles while in READ or WRITE; it is cleared on completion.
- When `wait_cnt` reaches WAIT_MAX with `mem_ready` still 0: abort → IDLE, `bus_err` ← 1, `data_bus_out` ← 8'hFF (on a read), no PC increment.
- `stall` = (READ or WRITE) and `mem_ready`=0. It is combinational from state and `mem_ready`.

**PC load**
- `pc_load` is honoured in any state.
- If it coincides with a PC increment, the load wins.

**Ignored requests**
- `rd`/`wr` outside IDLE are ignored.
- `rd`/`wr` in the same cycle as completion are not accepted. The decoder re-requests on its next T3.

## Timing
- Reset values: state IDLE, `mem_addr`=0, `mem_rd_n`=1, `mem_wr_n`=1, `mem_data_out`=0, `mem_data_oe`=0, `data_bus_out`=0, `pc`=RESET_PC, `wait_cnt`=0, `bus_err`=0, `stall`=0.
- Reset during READ/WRITE aborts immediately: strobes are high on the cycle after the reset edge, and there is no PC increment or data capture.
- Address setup: `mem_addr` is updated at the end of T2.
- Read, zero-wait: `rd` is sampled at the end of T3. Strobe is low during T4. Data is captured at the T4→T1 edge and is valid in `data_bus_out` throughout the next T1 (the `m1t1` cycle).
- Each low `mem_ready` adds one cycle; `stall` is high for exactly those cycles.
- Write, zero-wait: strobe and `oe` are active for exactly one cycle (T4).
- `bus_err` clears only on reset.

## Structure
- Shared package `gb_pkg`:
  - bus FSM state enum
  - register encodings (A=111, B=000 … (HL)=110)
  - DBUS select codes (SBUS=00, ALU=01, MEM=10, DEBUG=11)
  - `RESET_PC`
- Sub-module `program_counter`: 16-bit register with load/increment priority (load > increment > hold) and synchronous reset.
- FSM, wait counter and data buffer stay in `bus_ctrl`.

## Test plan
- Fetch: after reset, `reg_drive_addr`=0, `mem_data_in`=8'h3C, `mem_ready`=1, `rd` pulsed at T3 → `mem_addr`=0000, `mem_rd_n` low one cycle, `data_bus_out`=3C at next T1, `pc`=0001.
- HL read with waits: `reg_drive_addr`=1, `reg_addr_in`=C000, `mem_ready` low 3 cycles → `stall` high 3 cycles, `mem_rd_n` low 4 cycles, data captured, `pc` unchanged.
- Write: `wr`=1, `wr_data`=A5, `reg_addr_in`=FF80 → `mem_addr`=FF80, `mem_wr_n` and `mem_data_oe` asserted with `mem_data_out`=A5 for one cycle.
- Timeout: `mem_ready` held 0 → abort after 15 wait cycles, `bus_err`=1, `data_bus_out`=FF, `pc` unchanged.
- Wrap/priority: `pc`=FFFF fetch → `pc`=0000; `pc_load`=1 with `pc_load_val`=0150 on the completion edge → `pc`=0150.
- Reset mid-READ: assert `rst` during a wait state → next cycle IDLE, `mem_rd_n`=1, `pc`=0000, `data_bus_out`=00, `bus_err`=0.
